issue_control: RTL

Single-entry issue stage between the decode unit and the INT/LSU/VEC execution units. It captures one decoded instruction per handshake, holds it until its destination unit accepts it, and blocks issue on register hazards (pending-write scoreboard) and on LSU outstanding-request overflow. It raises an illegal-instruction trap when decode reports no execution unit.

---
 rtl/core101_pkg.sv | 30 +++
 rtl/issue_scoreboard.sv | 39 +++
 rtl/issue_control.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/core101_pkg.sv
// Shared definitions for the core101 issue path: unit-select codes,
// issue FSM encoding and the default LSU outstanding limit.
package core101_pkg;

    // One-hot execution unit selects as produced by decode
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_INT  = 3'b001;
    localparam logic [2:0] SEL_LSU  = 3'b010;
    localparam logic [2:0] SEL_VEC  = 3'b100;

    // Issue FSM encoding
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HELD  = 2'd1;
    localparam logic [1:0] ST_TRAP  = 2'd2;

    localparam int LSU_MAX_OUT_DEF = 2;

    // Fields captured from decode and held until issue
    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] uop;
        logic       pc_mux_sel;
        logic       imm_mux_sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       writes_rd;
    } issue_ins_t;

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writing instruction issues, cleared on writeback. Register x0 never gets
// marked so it can never cause a stall.
module issue_scoreboard (
    input  logic       clock_in,
    input  logic       reset_n_in,
    input  logic       set_en_in,
    input  logic [4:0] set_idx_in,
    input  logic       clr_en_in,
    input  logic [4:0] clr_idx_in,
    input  logic [4:0] rs1_idx_in,
    input  logic [4:0] rs2_idx_in,
    input  logic [4:0] rd_idx_in,
    output logic       rs1_busy_out,
    output logic       rs2_busy_out,
    output logic       rd_busy_out
);

    logic [31:0] r_busy;

    // Clear first, then set, so a same-register set/clear leaves the bit set
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_busy <= '0;
        end else begin
            if (clr_en_in) begin
                r_busy[clr_idx_in] <= 1'b0;
            end
            if (set_en_in && (set_idx_in != 5'd0)) begin
                r_busy[set_idx_in] <= 1'b1;
            end
        end
    end

    assign rs1_busy_out = r_busy[rs1_idx_in];
    assign rs2_busy_out = r_busy[rs2_idx_in];
    assign rd_busy_out  = r_busy[rd_idx_in];

endmodule

// File: rtl/issue_control.sv
// Single-entry issue stage between decode and the INT/LSU/VEC units.
// Holds one instruction, stalls it on pending register writes or a full
// LSU outstanding window, and traps when decode names no unit.
//
//  state    | meaning
//  ---------+-------------------------------------------
//  ST_EMPTY | no instruction held, decode may hand over
//  ST_HELD  | instruction held, offered once unblocked
//  ST_TRAP  | illegal instruction captured, await ack
module issue_control
    import core101_pkg::*;
#(
    parameter int LSU_MAX_OUT = LSU_MAX_OUT_DEF
) (
    input  logic       clock_in,
    input  logic       reset_n_in,
    input  logic       dec_valid_in,
    output logic       dec_ready_out,
    input  logic [2:0] exec_unit_sel_in,
    input  logic [3:0] exec_unit_uop_in,
    input  logic       pc_mux_sel_in,
    input  logic       imm_mux_sel_in,
    input  logic [4:0] rs1_in,
    input  logic [4:0] rs2_in,
    input  logic [4:0] rd_in,
    input  logic       writes_rd_in,
    output logic [2:0] issue_valid_out,
    input  logic [2:0] unit_ready_in,
    output logic [3:0] issue_uop_out,
    output logic       issue_pc_mux_sel_out,
    output logic       issue_imm_mux_sel_out,
    output logic [4:0] issue_rs1_out,
    output logic [4:0] issue_rs2_out,
    output logic [4:0] issue_rd_out,
    input  logic       wb_valid_in,
    input  logic [4:0] wb_rd_in,
    input  logic       lsu_done_in,
    input  logic       flush_in,
    output logic       illegal_ins_out,
    input  logic       trap_ack_in
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    issue_ins_t r_ins;
    logic [2:0] r_lsu_count;

    logic w_rs1_busy;
    logic w_rs2_busy;
    logic w_rd_busy;
    logic w_lsu_full;
    logic w_blocked;
    logic w_fire;
    logic w_capture;
    logic w_lsu_inc;
    logic w_lsu_dec;
    logic w_sb_set;

    issue_scoreboard u_scoreboard (
        .clock_in     (clock_in),
        .reset_n_in   (reset_n_in),
        .set_en_in    (w_sb_set),
        .set_idx_in   (r_ins.rd),
        .clr_en_in    (wb_valid_in),
        .clr_idx_in   (wb_rd_in),
        .rs1_idx_in   (r_ins.rs1),
        .rs2_idx_in   (r_ins.rs2),
        .rd_idx_in    (r_ins.rd),
        .rs1_busy_out (w_rs1_busy),
        .rs2_busy_out (w_rs2_busy),
        .rd_busy_out  (w_rd_busy)
    );

    // Hazards only use registered state, so once the held instruction is
    // unblocked it stays unblocked until it fires: the scoreboard only sets
    // on fire and the LSU count only grows on fire.
    assign w_lsu_full = (r_lsu_count == 3'(LSU_MAX_OUT));
    assign w_blocked  = w_rs1_busy | w_rs2_busy | (r_ins.writes_rd & w_rd_busy)
                      | ((r_ins.sel == SEL_LSU) & w_lsu_full);

    assign issue_valid_out = ((r_state == ST_HELD) && !w_blocked) ? r_ins.sel : 3'b000;

    // A flush cancels any handshake in the same cycle
    assign w_fire        = (|(issue_valid_out & unit_ready_in)) & ~flush_in;
    assign dec_ready_out = ~flush_in & ((r_state == ST_EMPTY) | ((r_state == ST_HELD) & w_fire));
    assign w_capture     = dec_valid_in & dec_ready_out;

    assign w_sb_set  = w_fire & r_ins.writes_rd;
    assign w_lsu_inc = w_fire & (r_ins.sel == SEL_LSU);
    assign w_lsu_dec = lsu_done_in & (r_lsu_count != 3'd0);

    assign illegal_ins_out       = (r_state == ST_TRAP);
    assign issue_uop_out         = r_ins.uop;
    assign issue_pc_mux_sel_out  = r_ins.pc_mux_sel;
    assign issue_imm_mux_sel_out = r_ins.imm_mux_sel;
    assign issue_rs1_out         = r_ins.rs1;
    assign issue_rs2_out         = r_ins.rs2;
    assign issue_rd_out          = r_ins.rd;

    // Next-state decode for the issue FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_capture) begin
                    w_state_nxt = (exec_unit_sel_in == SEL_NONE) ? ST_TRAP : ST_HELD;
                end
            end
            ST_HELD: begin
                if (flush_in) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_capture) begin
                    w_state_nxt = (exec_unit_sel_in == SEL_NONE) ? ST_TRAP : ST_HELD;
                end else if (w_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TRAP: begin
                if (flush_in || trap_ack_in) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture all decode fields on the handshake
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_ins <= '0;
        end else if (w_capture) begin
            r_ins.sel         <= exec_unit_sel_in;
            r_ins.uop         <= exec_unit_uop_in;
            r_ins.pc_mux_sel  <= pc_mux_sel_in;
            r_ins.imm_mux_sel <= imm_mux_sel_in;
            r_ins.rs1         <= rs1_in;
            r_ins.rs2         <= rs2_in;
            r_ins.rd          <= rd_in;
            r_ins.writes_rd   <= writes_rd_in;
        end
    end

    // LSU outstanding count; simultaneous issue and completion cancel out
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_lsu_count <= 3'd0;
        end else begin
            case ({w_lsu_inc, w_lsu_dec})
                2'b10:   r_lsu_count <= r_lsu_count + 3'd1;
                2'b01:   r_lsu_count <= r_lsu_count - 3'd1;
                default: r_lsu_count <= r_lsu_count;
            endcase
        end
    end

endmodule
